// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: sequences game, play and timeout/break clocks across four quarters (optional two-minute auto-stop: TWO_MIN_WARNING_EN)
module game_flow_ctrl #(
    parameter int QTR_SECS     = 600,
    parameter int PLAY_SECS    = 15,
    parameter int TIMEOUT_SECS = 30,
    parameter int BREAK_SECS   = 120,
    parameter int HALF_SECS    = 300,
    parameter int TO_PER_HALF  = 3
) (
    input  logic       toggle,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       start_stop,
    input  logic       snap,
    input  logic       possession,
    input  logic       to_req_home,
    input  logic       to_req_away,
    output logic [9:0] game_secs,
    output logic [5:0] play_secs,
    output logic [8:0] aux_secs,
    output logic [2:0] quarter,
    output logic [2:0] state,
    output logic [1:0] to_left_home,
    output logic [1:0] to_left_away,
    output logic       delay_flag,
    output logic       two_min_warn
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUNNING  = 3'd1,
        STOPPED  = 3'd2,
        TIMEOUT  = 3'd3,
        BREAK    = 3'd4,
        HALFTIME = 3'd5,
        FINAL    = 3'd6
    } state_t;

    localparam logic [9:0] QTR  = 10'(QTR_SECS);
    localparam logic [5:0] PLAY = 6'(PLAY_SECS);
    localparam logic [8:0] TOUT = 9'(TIMEOUT_SECS);
    localparam logic [8:0] BRK  = 9'(BREAK_SECS);
    localparam logic [8:0] HALF = 9'(HALF_SECS);
    localparam logic [1:0] TOPH = 2'(TO_PER_HALF);

    state_t     cur, nxt;
    logic [9:0] game_n;
    logic [5:0] play_n;
    logic [8:0] aux_n;
    logic [2:0] qtr_n;
    logic [1:0] home_n, away_n;
    logic       dly_n, poss_q, reload, home_ok, away_ok, last_tick, warn_hit;

    assign state = cur;
    assign reload = (snap || possession != poss_q) && (cur == RUNNING || cur == STOPPED || cur == TIMEOUT);
    assign home_ok = to_req_home && to_left_home != 2'd0;
    assign away_ok = to_req_away && to_left_away != 2'd0;
    assign last_tick = sec_tick && game_secs == 10'd1;

`ifdef TWO_MIN_WARNING_EN
    logic fired, fired_n, warn_n;
    assign warn_hit = sec_tick && game_secs == 10'd121 && (quarter == 3'd2 || quarter == 3'd4) && !fired;

    // Two-minute warning pulse and its once-per-quarter arm bit
    always_ff @(posedge toggle or posedge reset) begin
        if (reset) begin
            fired        <= 1'b0;
            two_min_warn <= 1'b0;
        end else begin
            fired        <= fired_n;
            two_min_warn <= warn_n;
        end
    end
`else
    assign warn_hit = 1'b0;
    assign two_min_warn = 1'b0;
`endif

    // Register state, clocks, counters and the previous possession level
    always_ff @(posedge toggle or posedge reset) begin
        if (reset) begin
            cur          <= IDLE;
            game_secs    <= QTR;
            play_secs    <= PLAY;
            aux_secs     <= 9'd0;
            quarter      <= 3'd0;
            to_left_home <= TOPH;
            to_left_away <= TOPH;
            delay_flag   <= 1'b0;
            poss_q       <= 1'b0;
        end else begin
            cur          <= nxt;
            game_secs    <= game_n;
            play_secs    <= play_n;
            aux_secs     <= aux_n;
            quarter      <= qtr_n;
            to_left_home <= home_n;
            to_left_away <= away_n;
            delay_flag   <= dly_n;
            poss_q       <= possession;
        end
    end

    // Next state and next datapath values; quarter end beats warning beats timeouts beats start/stop
    always_comb begin
        nxt    = cur;
        game_n = game_secs;
        play_n = play_secs;
        aux_n  = aux_secs;
        qtr_n  = quarter;
        home_n = to_left_home;
        away_n = to_left_away;
        dly_n  = delay_flag;
`ifdef TWO_MIN_WARNING_EN
        fired_n = fired;
        warn_n  = 1'b0;
`endif
        case (cur)
            IDLE: begin
                if (start_stop) begin
                    nxt   = RUNNING;
                    qtr_n = 3'd1;
                end
            end
            RUNNING, STOPPED: begin
                if (cur == RUNNING && sec_tick) begin
                    game_n = (game_secs == 10'd0) ? 10'd0 : game_secs - 10'd1;
                    play_n = (play_secs == 6'd0) ? 6'd0 : play_secs - 6'd1;
                    dly_n  = delay_flag || play_n == 6'd0;
                end
                if (cur == RUNNING && last_tick) begin
                    nxt   = (quarter == 3'd4) ? FINAL : (quarter == 3'd2) ? HALFTIME : BREAK;
                    aux_n = (quarter == 3'd4) ? 9'd0 : (quarter == 3'd2) ? HALF : BRK;
                    if (quarter == 3'd2) begin
                        home_n = TOPH;
                        away_n = TOPH;
                    end
                end else if (cur == RUNNING && warn_hit) begin
                    nxt = STOPPED;
`ifdef TWO_MIN_WARNING_EN
                    warn_n  = 1'b1;
                    fired_n = 1'b1;
`endif
                end else if (home_ok) begin
                    nxt    = TIMEOUT;
                    aux_n  = TOUT;
                    home_n = to_left_home - 2'd1;
                end else if (away_ok) begin
                    nxt    = TIMEOUT;
                    aux_n  = TOUT;
                    away_n = to_left_away - 2'd1;
                end else if (start_stop) begin
                    nxt = (cur == RUNNING) ? STOPPED : RUNNING;
                end
            end
            TIMEOUT, BREAK, HALFTIME: begin
                if (aux_secs == 9'd0) begin
                    nxt = STOPPED;
                    if (cur != TIMEOUT) begin
                        qtr_n  = quarter + 3'd1;
                        game_n = QTR;
                        play_n = PLAY;
                        dly_n  = 1'b0;
`ifdef TWO_MIN_WARNING_EN
                        fired_n = 1'b0;
`endif
                    end
                end else if (sec_tick) begin
                    aux_n = aux_secs - 9'd1;
                end
            end
            FINAL: nxt = FINAL;
            default: nxt = IDLE;
        endcase
        if (reload) begin
            play_n = PLAY;
            dly_n  = 1'b0;
        end
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed game walk plus random stimulus checked against a behavioural model
module tb_game_flow_ctrl;
    localparam int QTR_SECS = 600, PLAY_SECS = 15, TIMEOUT_SECS = 30;
    localparam int BREAK_SECS = 120, HALF_SECS = 300, TO_PER_HALF = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_TO = 3, S_BRK = 4, S_HALF = 5, S_FIN = 6;
`ifdef TWO_MIN_WARNING_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    logic       toggle = 1'b0, reset = 1'b0;
    logic       sec_tick = 1'b0, start_stop = 1'b0, snap = 1'b0, possession = 1'b0;
    logic       to_req_home = 1'b0, to_req_away = 1'b0;
    logic [9:0] game_secs;
    logic [5:0] play_secs;
    logic [8:0] aux_secs;
    logic [2:0] quarter, state;
    logic [1:0] to_left_home, to_left_away;
    logic       delay_flag, two_min_warn;

    int  errors = 0, checks = 0;
    bit  chk_en = 1'b0;
    int  m_state, m_game, m_play, m_aux, m_q, m_th, m_ta;
    bit  m_dly, m_warn, m_fired, m_poss;

    game_flow_ctrl #(
        .QTR_SECS(QTR_SECS), .PLAY_SECS(PLAY_SECS), .TIMEOUT_SECS(TIMEOUT_SECS),
        .BREAK_SECS(BREAK_SECS), .HALF_SECS(HALF_SECS), .TO_PER_HALF(TO_PER_HALF)
    ) dut (
        .toggle(toggle), .reset(reset), .sec_tick(sec_tick), .start_stop(start_stop),
        .snap(snap), .possession(possession), .to_req_home(to_req_home), .to_req_away(to_req_away),
        .game_secs(game_secs), .play_secs(play_secs), .aux_secs(aux_secs), .quarter(quarter),
        .state(state), .to_left_home(to_left_home), .to_left_away(to_left_away),
        .delay_flag(delay_flag), .two_min_warn(two_min_warn)
    );

    always #5 toggle = ~toggle;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_game = QTR_SECS; m_play = PLAY_SECS; m_aux = 0; m_q = 0;
        m_th = TO_PER_HALF; m_ta = TO_PER_HALF; m_dly = 0; m_warn = 0; m_fired = 0; m_poss = 0;
    endtask

    task automatic model_step();
        bit rl, ho, ao, q_end, wrn;
        rl = (snap || possession != m_poss) && (m_state == S_RUN || m_state == S_STOP || m_state == S_TO);
        m_poss = possession;
        m_warn = 0;
        ho = to_req_home && m_th > 0;
        ao = !ho && to_req_away && m_ta > 0;
        if (m_state == S_IDLE) begin
            if (start_stop) begin m_state = S_RUN; m_q = 1; end
        end else if (m_state == S_RUN || m_state == S_STOP) begin
            q_end = m_state == S_RUN && sec_tick && m_game == 1;
            wrn = WARN_EN && m_state == S_RUN && sec_tick && m_game == 121 && (m_q == 2 || m_q == 4) && !m_fired;
            if (m_state == S_RUN && sec_tick) begin
                m_game = m_game > 0 ? m_game - 1 : 0;
                m_play = m_play > 0 ? m_play - 1 : 0;
                if (m_play == 0) m_dly = 1;
            end
            if (q_end) begin
                if (m_q == 4) m_state = S_FIN;
                else if (m_q == 2) begin
                    m_state = S_HALF; m_aux = HALF_SECS; m_th = TO_PER_HALF; m_ta = TO_PER_HALF;
                end else begin
                    m_state = S_BRK; m_aux = BREAK_SECS;
                end
            end else if (wrn) begin
                m_state = S_STOP; m_warn = 1; m_fired = 1;
            end else if (ho) begin
                m_th--; m_state = S_TO; m_aux = TIMEOUT_SECS;
            end else if (ao) begin
                m_ta--; m_state = S_TO; m_aux = TIMEOUT_SECS;
            end else if (start_stop) m_state = (m_state == S_RUN) ? S_STOP : S_RUN;
        end else if (m_state != S_FIN) begin
            if (m_aux == 0) begin
                if (m_state != S_TO) begin
                    m_q++; m_game = QTR_SECS; m_play = PLAY_SECS; m_dly = 0; m_fired = 0;
                end
                m_state = S_STOP;
            end else if (sec_tick) m_aux--;
        end
        if (rl) begin m_play = PLAY_SECS; m_dly = 0; end
    endtask

    // Reference model advances on the same edges as the design
    always @(posedge toggle or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // Every cycle, all outputs must match the model
    always @(negedge toggle) begin
        if (chk_en) begin
            cmp("state", state, m_state);
            cmp("game_secs", game_secs, m_game);
            cmp("play_secs", play_secs, m_play);
            cmp("aux_secs", aux_secs, m_aux);
            cmp("quarter", quarter, m_q);
            cmp("to_left_home", to_left_home, m_th);
            cmp("to_left_away", to_left_away, m_ta);
            cmp("delay_flag", delay_flag, m_dly);
            cmp("two_min_warn", two_min_warn, m_warn);
        end
    end

    task automatic step(input bit tk, input bit ss, input bit sn, input bit th, input bit ta);
        sec_tick = tk; start_stop = ss; snap = sn; to_req_home = th; to_req_away = ta;
        @(posedge toggle);
        #1;
        sec_tick = 0; start_stop = 0; snap = 0; to_req_home = 0; to_req_away = 0;
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 1300 && m_game > target; n++) begin
            if (m_state == S_STOP) step(0, 1, 0, 0, 0);
            else step(1, 0, 0, 0, 0);
        end
        cmp("run_to_game", game_secs, target);
    endtask

    task automatic wait_stop();
        for (int n = 0; n < 400 && m_state != S_STOP; n++) step(1, 0, 0, 0, 0);
        cmp("wait_stop_state", state, S_STOP);
    endtask

    task automatic do_reset();
        #2;
        reset = 1;
        #1;
        cmp("rst_state", state, S_IDLE);
        cmp("rst_game", game_secs, 600);
        cmp("rst_play", play_secs, 15);
        cmp("rst_aux", aux_secs, 0);
        cmp("rst_quarter", quarter, 0);
        cmp("rst_to", {to_left_home, to_left_away}, 4'b1111);
        cmp("rst_flags", {delay_flag, two_min_warn}, 0);
        possession = 0;
        repeat (2) @(posedge toggle);
        #1;
        reset = 0;
    endtask

    initial begin
        chk_en = 1;
        do_reset();
        step(0, 1, 0, 0, 0);
        repeat (10) step(1, 0, 0, 0, 0);
        cmp("t1_state", state, S_RUN);
        cmp("t1_quarter", quarter, 1);
        cmp("t1_game", game_secs, 590);
        cmp("t1_play", play_secs, 5);
        repeat (5) step(1, 0, 0, 0, 0);
        cmp("t2_play", play_secs, 0);
        cmp("t2_delay", delay_flag, 1);
        step(0, 0, 1, 0, 0);
        cmp("snap_play", play_secs, 15);
        cmp("snap_delay", delay_flag, 0);
        step(1, 0, 0, 0, 0);
        cmp("tick_play", play_secs, 14);
        possession = 1;
        step(0, 0, 0, 0, 0);
        cmp("poss_play", play_secs, 15);
        step(0, 1, 0, 0, 0);
        cmp("stop_state", state, S_STOP);
        step(0, 0, 0, 1, 1);
        cmp("to_state", state, S_TO);
        cmp("to_home", to_left_home, 2);
        cmp("to_away", to_left_away, 3);
        cmp("to_aux", aux_secs, 30);
        repeat (30) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        cmp("to_end_state", state, S_STOP);
        cmp("to_end_game", game_secs, 584);
        step(0, 1, 0, 0, 0);
        run_to(0);
        cmp("q1_end_state", state, S_BRK);
        cmp("q1_end_aux", aux_secs, 120);
        wait_stop();
        cmp("q2_quarter", quarter, 2);
        step(0, 1, 0, 0, 0);
        run_to(1);
        if (m_state == S_STOP) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        cmp("half_state", state, S_HALF);
        cmp("half_aux", aux_secs, 300);
        cmp("half_to", {to_left_home, to_left_away}, 4'b1111);
        wait_stop();
        cmp("q3_quarter", quarter, 3);
        cmp("q3_game", game_secs, 600);
        step(0, 1, 0, 0, 0);
        run_to(0);
        wait_stop();
        step(0, 1, 0, 0, 0);
        run_to(121);
        step(1, 0, 0, 0, 0);
        cmp("warn_game", game_secs, 120);
        cmp("warn_state", state, WARN_EN ? S_STOP : S_RUN);
        cmp("warn_pulse", two_min_warn, WARN_EN ? 1 : 0);
        run_to(0);
        cmp("final_state", state, S_FIN);
        cmp("final_quarter", quarter, 4);
        for (int i = 0; i < 20; i++) begin
            possession = $urandom_range(0, 1);
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end
        cmp("final_hold_state", state, S_FIN);
        cmp("final_hold_game", game_secs, 0);
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 31) == 0) possession = ~possession;
            step($urandom_range(0, 1), $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end
        @(negedge toggle);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
